sram_fabric_port: RTL and testbench
===================================

# sram_fabric_port

Fabric-side initiator for the configurable SRAM cluster interface. Accepts word-level read/write requests over a valid/ready handshake, maps a flat word address onto the row, cluster-select and bit-position fields for the active width configuration, drives the interface's registered input pins, and returns read data in order after the fixed pipeline latency. Sits between fabric user logic and the SRAM cluster interface.

## Interface
- RD_LAT, 3, clock edges from the launch edge to the edge at which `d_out` is sampled; range 2..7
- RESET_CONF, 3'b101, value of the configuration register after reset (32-bit mode)

- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- conf_in  in  3  requested width configuration: 101=x32, 100=x16, 011=x8, 010=x4, 001=x2, 000=x1; 110/111 invalid
- req_valid  in  1  request present
- req_ready  out  1  request accepted on edges where valid & ready
- req_we  in  1  1=write, 0=read
- req_addr  in  14  flat word address
- req_wdata  in  32  write data, low W bits used
- rsp_valid  out  1  one-cycle read-response strobe
- rsp_data  out  32  read data, low W bits, upper bits zero
- rsp_err  out  1  qualifies rsp_valid: request was issued under an invalid conf
- d_fabric, csb, web, addr[8:0], addr_2_4[1:0], addr_3_8[2:0], conf[2:0]  out  interface pins, all registered
- d_out  in  32  read data from the interface

## Operation
- Widths W = 32/16/8/4/2/1; depth = 16384/W; req_addr bits above log2(depth) ignored.
- Field mapping from req_addr (a):
  - addr = a[8:0] in all modes.
  - x32: addr_2_4=0, addr_3_8=0.
  - x16: addr_2_4={a[9],0}, addr_3_8=0.
  - x8: addr_2_4=a[10:9], addr_3_8=0.
  - x4: addr_2_4=a[10:9], addr_3_8={a[11],00}.
  - x2: addr_2_4=a[10:9], addr_3_8={a[12:11],0}.
  - x1: addr_2_4=a[10:9], addr_3_8=a[13:11].
- Write: d_fabric = req_wdata masked to low W bits; csb=0, web=0 for one cycle.
- Read: csb=0, web=1 for one cycle; a read tag (valid, err) enters an RD_LAT-deep shift register.
- Idle cycle (no accept): csb=1, web=1, d_fabric/addr fields hold their last values.
- Invalid conf_reg: an accepted request drives csb=1 (no access). A read still gets a tag with err=1 and returns rsp_data=0, rsp_err=1. A write is silently dropped.
- Configuration register conf_reg drives `conf`. It loads conf_in only on a cycle where the in-flight read count is 0 and no request is accepted.
- req_ready = !(conf_in != conf_reg) && !rst. A pending change therefore stalls new requests until all reads drain and conf_reg updates, then ready returns the following cycle.
- The in-flight counter, width 3, increments on a read accept and decrements on tag retire; simultaneous events leave it unchanged.
- Responses are strictly in request order; there is no response backpressure.

## Timing
- Reset values: csb=1, web=1, d_fabric=0, addr=0, addr_2_4=0, addr_3_8=0, conf=RESET_CONF, rsp_valid=0, rsp_data=0, rsp_err=0, tag shift register cleared, counter=0.
- Accept at edge E: pins reflect the request from E until E+1.
- Read accepted at E: d_out sampled at edge E+RD_LAT, masked, registered. rsp_valid is high for exactly the cycle following E+RD_LAT.
- Back-to-back accepts are allowed every cycle, including mixed read/write and a read of an address written on the preceding cycle.
- Reset mid-operation: all in-flight tags are discarded; no rsp_valid is produced after rst deasserts.
- conf_in changing while reads are in flight: ready deasserts the same cycle (combinational). conf_reg updates on the first edge with counter=0 and no accept. conf changes on the pins at that edge.

## Test plan
- Reset, conf x32: write 0xDEADBEEF to addr 0x005, then read 0x005 on the next cycle -> rsp_valid 3 cycles after the read accept, rsp_data=0xDEADBEEF; pins during the write show csb=0, web=0, addr=0x005.
- Reset, conf_in=001 (x2): read a=0x1A03 -> addr=0x003, addr_2_4=01, addr_3_8=110; d_out=0xFFFFFFFF returns rsp_data=0x00000003.
- Four back-to-back reads in x8 mode -> four consecutive rsp_valid cycles with in-order data; counter peaks at 3.
- Two reads outstanding, conf_in 101->011 -> req_ready low until both responses retire; conf pins=011 one edge later; ready high next cycle.
- conf_in=111: read 0x010 -> csb stays 1; response has rsp_data=0, rsp_err=1. A write produces no pin access.
- Assert rst one cycle after a read accept -> all outputs return to reset values immediately, and no rsp_valid follows.

Source files
------------

// File: rtl/sram_fabric_port.sv
// Fabric-side initiator for the configurable SRAM cluster interface: maps flat word
// requests onto row/cluster pins and returns masked read data in order after RD_LAT edges.
module sram_fabric_port #(
  parameter int unsigned RD_LAT     = 3,
  parameter logic [2:0]  RESET_CONF = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  conf_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] d_fabric,
  output logic        csb,
  output logic        web,
  output logic [8:0]  addr,
  output logic [1:0]  addr_2_4,
  output logic [2:0]  addr_3_8,
  output logic [2:0]  conf,
  input  logic [31:0] d_out
);

  function automatic logic [31:0] width_mask(input logic [2:0] c);
    case (c)
      3'b101:  width_mask = 32'hFFFF_FFFF;
      3'b100:  width_mask = 32'h0000_FFFF;
      3'b011:  width_mask = 32'h0000_00FF;
      3'b010:  width_mask = 32'h0000_000F;
      3'b001:  width_mask = 32'h0000_0003;
      3'b000:  width_mask = 32'h0000_0001;
      default: width_mask = 32'h0000_0000;
    endcase
  endfunction

  logic [2:0]        conf_r;
  logic [2:0]        cnt_r;
  logic [RD_LAT-1:0] tag_v_r;
  logic [RD_LAT-1:0] tag_e_r;
  logic              accept_s;
  logic              rd_acc_s;
  logic              retire_s;
  logic              conf_ok_s;
  logic [31:0]       mask_s;
  logic [1:0]        a24_s;
  logic [2:0]        a38_s;

  // A pending width change blocks new requests until conf_r has caught up.
  assign req_ready = (conf_in == conf_r) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign rd_acc_s  = accept_s && !req_we;
  assign retire_s  = tag_v_r[RD_LAT-1];
  assign conf_ok_s = (conf_r <= 3'b101);
  assign mask_s    = width_mask(conf_r);
  assign conf      = conf_r;

  // Cluster-select and bit-position fields for the active width.
  always_comb begin
    a24_s = 2'b00;
    a38_s = 3'b000;
    case (conf_r)
      3'b101: begin a24_s = 2'b00;                 a38_s = 3'b000; end
      3'b100: begin a24_s = {req_addr[9], 1'b0};   a38_s = 3'b000; end
      3'b011: begin a24_s = req_addr[10:9];        a38_s = 3'b000; end
      3'b010: begin a24_s = req_addr[10:9];        a38_s = {req_addr[11], 2'b00}; end
      3'b001: begin a24_s = req_addr[10:9];        a38_s = {req_addr[12:11], 1'b0}; end
      3'b000: begin a24_s = req_addr[10:9];        a38_s = req_addr[13:11]; end
      default: begin a24_s = 2'b00;                a38_s = 3'b000; end
    endcase
  end

  // Interface pin registers; fields hold between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csb      <= 1'b1;
      web      <= 1'b1;
      d_fabric <= 32'h0000_0000;
      addr     <= 9'h000;
      addr_2_4 <= 2'b00;
      addr_3_8 <= 3'b000;
    end else if (accept_s && conf_ok_s) begin
      csb      <= 1'b0;
      web      <= !req_we;
      addr     <= req_addr[8:0];
      addr_2_4 <= a24_s;
      addr_3_8 <= a38_s;
      if (req_we) begin
        d_fabric <= req_wdata & mask_s;
      end
    end else begin
      csb <= 1'b1;
      web <= 1'b1;
    end
  end

  // Read tag pipeline: a tag reaches the last stage at the edge where d_out is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_r <= '0;
      tag_e_r <= '0;
    end else begin
      tag_v_r <= {tag_v_r[RD_LAT-2:0], rd_acc_s};
      tag_e_r <= {tag_e_r[RD_LAT-2:0], rd_acc_s && !conf_ok_s};
    end
  end

  // In-flight read counter; conf_r only moves once the pipeline is empty and idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= 3'd0;
      conf_r <= RESET_CONF;
    end else begin
      case ({rd_acc_s, retire_s})
        2'b10:   cnt_r <= cnt_r + 3'd1;
        2'b01:   cnt_r <= cnt_r - 3'd1;
        default: cnt_r <= cnt_r;
      endcase
      if ((cnt_r == 3'd0) && !accept_s) begin
        conf_r <= conf_in;
      end else begin
        conf_r <= conf_r;
      end
    end
  end

  // Response register; conf_r cannot change while a tag is in flight, so mask_s is the issue width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= retire_s;
      rsp_err   <= retire_s && tag_e_r[RD_LAT-1];
      if (retire_s && !tag_e_r[RD_LAT-1]) begin
        rsp_data <= d_out & mask_s;
      end else begin
        rsp_data <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_sram_fabric_port.sv
// Self-checking bench for sram_fabric_port: directed scenarios plus random traffic
// checked against a cycle-indexed behavioural model of requests, pins and responses.
module tb_sram_fabric_port;
  localparam int RD_LAT = 3;
  localparam logic [2:0] RESET_CONF = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  conf_in;
  logic        req_valid, req_ready, req_we;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data, d_fabric, d_out;
  logic        csb, web;
  logic [8:0]  addr;
  logic [1:0]  addr_2_4;
  logic [2:0]  addr_3_8, conf;

  sram_fabric_port #(.RD_LAT(RD_LAT), .RESET_CONF(RESET_CONF)) dut (
    .clk(clk), .rst(rst), .conf_in(conf_in), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .d_fabric(d_fabric), .csb(csb), .web(web),
    .addr(addr), .addr_2_4(addr_2_4), .addr_3_8(addr_3_8), .conf(conf), .d_out(d_out)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
  rsp_t        exp_q[$];
  int          rd_cyc[$];
  logic [31:0] mem [int];
  logic [31:0] dq [0:8191];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  logic [2:0]  m_conf;
  logic        m_csb, m_web;
  logic [31:0] m_dfab;
  logic [8:0]  m_addr;
  logic [1:0]  m_a24;
  logic [2:0]  m_a38;

  function automatic int width_of(input logic [2:0] c);
    case (c)
      3'd5: return 32;  3'd4: return 16;  3'd3: return 8;
      3'd2: return 4;   3'd1: return 2;   3'd0: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    if (w == 32) return 32'hFFFF_FFFF;
    return (32'h1 << w) - 32'h1;
  endfunction

  // Row = low 9 bits of the in-range address; the rest splits into 4 clusters x bit groups.
  function automatic void map_fields(input int w, input int a, output logic [8:0] ad,
                                     output logic [1:0] a24, output logic [2:0] a38);
    int aeff, upper, groups;
    aeff   = a % (16384 / w);
    upper  = aeff / 512;
    ad     = 9'(aeff % 512);
    a24    = 2'(upper % 4);
    groups = (w >= 8) ? 1 : (8 / w) / 1;
    if (w == 16) a24 = 2'(upper * 2);
    if (w >= 8) a38 = 3'd0;
    else a38 = 3'((upper / 4) * (8 / (32 / (w * 4) > 0 ? (w == 4 ? 2 : (w == 2 ? 4 : 8)) : 8)));
    if (groups < 0) a38 = 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_csb", 32'(csb), 32'd1);
    chk("rst_web", 32'(web), 32'd1);
    chk("rst_dfab", d_fabric, 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_a24", 32'(addr_2_4), 32'd0);
    chk("rst_a38", 32'(addr_3_8), 32'd0);
    chk("rst_conf", 32'(conf), 32'(RESET_CONF));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    rd_cyc.delete();
    m_conf = RESET_CONF;
    m_csb = 1'b1; m_web = 1'b1; m_dfab = 32'h0;
    m_addr = 9'h0; m_a24 = 2'b0; m_a38 = 3'b0;
  endtask

  task automatic cycle(input logic v, input logic we, input logic [13:0] a, input logic [31:0] wd);
    logic acc, rdy, load, exp_v;
    int w, n_in, key;
    logic [31:0] mk, dv;
    logic [8:0] ad;
    logic [1:0] f24;
    logic [2:0] f38;
    rsp_t r;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
    #1;
    rdy = (conf_in == m_conf) && !rst;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    acc = v && rdy;
    n_in = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= cyc + 1 - RD_LAT) n_in++;
    load = !acc && (n_in == 0);
    @(posedge clk);
    cyc++;
    w = width_of(m_conf);
    mk = (w == 0) ? 32'h0 : mask_of(w);
    key = (w == 0) ? 0 : int'(m_conf) * 16384 + (int'(a) % (16384 / w));
    if (rst) begin
      model_reset();
    end else begin
      if (acc && w != 0) begin
        map_fields(w, int'(a), ad, f24, f38);
        m_csb = 1'b0; m_web = !we; m_addr = ad; m_a24 = f24; m_a38 = f38;
        if (we) begin
          m_dfab = wd & mk;
          mem[key] = wd & mk;
        end
      end else begin
        m_csb = 1'b1; m_web = 1'b1;
      end
      if (acc && !we) begin
        rd_cyc.push_back(cyc);
        if (force_en) dv = force_val;
        else if (w != 0 && mem.exists(key)) dv = mem[key] | ($urandom & ~mk);
        else dv = $urandom;
        dq[cyc + RD_LAT] = dv;
        r.due = cyc + RD_LAT; r.err = (w == 0); r.data = dv & mk;
        exp_q.push_back(r);
      end
      if (load) m_conf = conf_in;
    end
    #1;
    chk("csb", 32'(csb), 32'(m_csb));
    chk("web", 32'(web), 32'(m_web));
    chk("d_fabric", d_fabric, m_dfab);
    chk("addr", 32'(addr), 32'(m_addr));
    chk("addr_2_4", 32'(addr_2_4), 32'(m_a24));
    chk("addr_3_8", 32'(addr_3_8), 32'(m_a38));
    chk("conf", 32'(conf), 32'(m_conf));
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      r = exp_q.pop_front();
      chk("rsp_data", rsp_data, r.data);
      chk("rsp_err", 32'(rsp_err), 32'(r.err));
    end
    d_out = dq[cyc + 1];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 14'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) dq[i] = $urandom;
    rst = 1'b1; conf_in = 3'b101; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 14'h0; req_wdata = 32'h0; d_out = 32'h0;
    model_reset();
    idle(2);
    chk_reset();
    rst = 1'b0;

    // x32 write then read of the same word.
    cycle(1'b1, 1'b1, 14'h005, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 14'h005, 32'h0);
    idle(RD_LAT + 1);

    // x2 mapping and masking.
    conf_in = 3'b001;
    idle(2);
    force_en = 1'b1; force_val = 32'hFFFF_FFFF;
    cycle(1'b1, 1'b0, 14'h1A03, 32'h0);
    force_en = 1'b0;
    idle(RD_LAT + 1);

    // x8: writes then four back-to-back reads of them.
    conf_in = 3'b011;
    idle(2);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 14'(16'h0600 + i * 16'h0205), $urandom);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 14'(16'h0600 + i * 16'h0205), 32'h0);
    idle(RD_LAT + 1);

    // Width change with two reads outstanding; requester keeps valid high.
    conf_in = 3'b101;
    idle(2);
    cycle(1'b1, 1'b0, 14'h0011, 32'h0);
    cycle(1'b1, 1'b0, 14'h0022, 32'h0);
    conf_in = 3'b011;
    for (int i = 0; i < RD_LAT + 4; i++) cycle(1'b1, 1'b0, 14'h0033, 32'h0);
    idle(RD_LAT + 1);

    // Invalid width: no pin access, read returns an error response.
    conf_in = 3'b111;
    idle(2);
    cycle(1'b1, 1'b0, 14'h0010, 32'h0);
    cycle(1'b1, 1'b1, 14'h0010, 32'h1234_5678);
    idle(RD_LAT + 1);

    // Random traffic with occasional width changes.
    conf_in = 3'b101;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0)
        conf_in = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 14'($urandom), $urandom);
    end
    idle(RD_LAT + 3);

    // Reset one cycle after a read accept discards the tag.
    conf_in = 3'b101;
    idle(2);
    cycle(1'b1, 1'b0, 14'h0044, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_reset();
    idle(2);
    rst = 1'b0;
    idle(RD_LAT + 3);

    chk("rsp_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
